// File: rtl/pair_exit_drain.sv
// Drains 192-bit records from the upstream pair exit FIFO into a small buffer and
// serializes each record to the host as six 32-bit words, least significant first.
// Optional build macro: PAIR_EXIT_DRAIN_ZERO_FILTER_EN drops captured all-zero records
// (the upstream FIFO presents zero when it was empty at read time).
module pair_exit_drain #(
  parameter int unsigned CAPTURE_PHASE = 2,
  parameter int unsigned BUF_DEPTH     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [191:0] fifo_out,
  input  logic         fifo_qempty,
  output logic         read_ctrl,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic [15:0]  rec_count
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {RIdle, RPulse, RWait} req_st_e;
  typedef enum logic {SIdle, SSend} ser_st_e;

  logic [3:0]      phase_q, phase_d;
  req_st_e         req_st_q, req_st_d;
  logic            read_ctrl_q, read_ctrl_d;
  logic            capture, push, pop;
  logic [191:0]    buf_q [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CntW-1:0] cnt_q, cnt_d;
  ser_st_e         ser_st_q, ser_st_d;
  logic [2:0]      idx_q, idx_d;
  logic            m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [31:0]     m_data_q, m_data_d;
  logic [15:0]     rec_count_q, rec_count_d;
  logic [5:0][31:0] head_w, next_w;

  // Request side: one read pulse per frame at phase 15, sample the record at CAPTURE_PHASE.
  // Only one request can be outstanding, so buffer count alone bounds occupancy in RIdle.
  always_comb begin
    phase_d     = phase_q + 4'd1;
    req_st_d    = req_st_q;
    read_ctrl_d = 1'b0;
    capture     = 1'b0;
    unique case (req_st_q)
      RIdle: begin
        if (phase_q == 4'd14 && !fifo_qempty && cnt_q < CntW'(BUF_DEPTH)) begin
          req_st_d    = RPulse;
          read_ctrl_d = 1'b1;
        end
      end
      RPulse: req_st_d = RWait;
      RWait: begin
        if (phase_q == 4'(CAPTURE_PHASE)) begin
          req_st_d = RIdle;
          capture  = 1'b1;
        end
      end
      default: req_st_d = RIdle;
    endcase
  end

  // Buffer admission: optionally drop all-zero (empty-masked) records.
  always_comb begin
`ifdef PAIR_EXIT_DRAIN_ZERO_FILTER_EN
    push = capture && (fifo_out != '0);
`else
    push = capture;
`endif
  end

  // Serializer: registered outputs only change on a handshake, so they hold under backpressure.
  always_comb begin
    head_w      = buf_q[rd_ptr_q];
    rd_ptr_nxt  = rd_ptr_q + PtrW'(1);
    next_w      = buf_q[rd_ptr_nxt];
    pop         = 1'b0;
    ser_st_d    = ser_st_q;
    idx_d       = idx_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    rec_count_d = rec_count_q;
    unique case (ser_st_q)
      SIdle: begin
        if (cnt_q != '0) begin
          ser_st_d  = SSend;
          idx_d     = 3'd0;
          m_valid_d = 1'b1;
          m_data_d  = head_w[0];
          m_last_d  = 1'b0;
        end
      end
      SSend: begin
        if (m_ready) begin
          if (idx_q == 3'd5) begin
            pop         = 1'b1;
            rec_count_d = rec_count_q + 16'd1;
            idx_d       = 3'd0;
            m_last_d    = 1'b0;
            // Back-to-back records when another one is already buffered.
            if (cnt_q > CntW'(1)) begin
              m_data_d = next_w[0];
            end else begin
              ser_st_d  = SIdle;
              m_valid_d = 1'b0;
              m_data_d  = '0;
            end
          end else begin
            idx_d    = idx_q + 3'd1;
            m_data_d = head_w[idx_d];
            m_last_d = (idx_d == 3'd5);
          end
        end
      end
      default: ser_st_d = SIdle;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  end

  // Record storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= fifo_out;
    end
  end

  // Control and output state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= 4'd15;
      req_st_q    <= RIdle;
      read_ctrl_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ser_st_q    <= SIdle;
      idx_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      rec_count_q <= '0;
    end else begin
      phase_q     <= phase_d;
      req_st_q    <= req_st_d;
      read_ctrl_q <= read_ctrl_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ser_st_q    <= ser_st_d;
      idx_q       <= idx_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign read_ctrl = read_ctrl_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_pair_exit_drain.sv
// Bench for pair_exit_drain: upstream FIFO model, host monitor and a record-level
// reference (expected word stream built from records as they leave the upstream FIFO).
`timescale 1ns/1ps
module tb_pair_exit_drain;
  localparam int unsigned BufDepth = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [191:0] fifo_out = '0;
  logic         fifo_qempty = 1'b1;
  logic         read_ctrl;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic [15:0]  rec_count;

  always #5 clk = ~clk;

  pair_exit_drain #(.CAPTURE_PHASE(2), .BUF_DEPTH(BufDepth)) dut (
    .clk(clk), .reset(reset), .fifo_out(fifo_out), .fifo_qempty(fifo_qempty),
    .read_ctrl(read_ctrl), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .rec_count(rec_count)
  );

  int checks = 0;
  int errors = 0;
  logic [191:0] up_q[$];
  logic [32:0]  exp_q[$];
  logic [32:0]  got_q[$];
  int exp_recs, pulses, bad_phase, unstable, valid_cycles, tb_ph;
  logic prev_hold = 1'b0;
  logic [32:0] prev_word = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit delivered(input logic [191:0] r);
`ifdef PAIR_EXIT_DRAIN_ZERO_FILTER_EN
    return r != '0;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: a record leaving the upstream FIFO shows up as six words, low word first.
  task automatic model_take(input logic [191:0] r);
    if (delivered(r)) begin
      for (int k = 0; k < 6; k++) exp_q.push_back({(k == 5), r[32*k +: 32]});
      exp_recs++;
    end
  endtask

  task automatic push_rec(input logic [191:0] r);
    up_q.push_back(r);
    fifo_qempty = 1'b0;
  endtask

  function automatic logic [191:0] rand_rec();
    logic [191:0] r;
    for (int k = 0; k < 6; k++) r[32*k +: 32] = $urandom;
    if ($urandom_range(0, 5) == 0) r = '0;
    return r;
  endfunction

  // Frame phase as the upstream FIFO sees it.
  initial begin
    tb_ph = 15;
    forever @(posedge clk) if (!reset) tb_ph = (tb_ph + 1) % 16;
  end

  // Upstream FIFO and host monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (m_valid) valid_cycles++;
      if (prev_hold && (!m_valid || {m_last, m_data} !== prev_word)) unstable++;
      prev_hold = m_valid && !m_ready;
      prev_word = {m_last, m_data};
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (read_ctrl) begin
        pulses++;
        if (tb_ph != 15) bad_phase++;
        if (up_q.size() > 0) fifo_out = up_q.pop_front();
        else fifo_out = '0;
        model_take(fifo_out);
        fifo_qempty = (up_q.size() == 0);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tb_ph = 15;
    up_q.delete(); exp_q.delete(); got_q.delete();
    exp_recs = 0; pulses = 0; bad_phase = 0; unstable = 0; valid_cycles = 0;
    prev_hold = 1'b0;
    fifo_out = '0; fifo_qempty = 1'b1; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggles every cycle, 2: random
  task automatic drive_ready(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int mode, input int max_cycles);
    int n = 0;
    while (!(up_q.size() == 0 && got_q.size() >= exp_q.size() && !m_valid) && n < max_cycles) begin
      drive_ready(mode);
      n++;
    end
    check({tag, " drain in time"}, 64'(n < max_cycles), 64'd1);
    repeat (40) drive_ready(mode);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, " word count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s word %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, " rec_count"}, 64'(rec_count), 64'(exp_recs[15:0]));
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    logic [191:0] r0, ra;
    int n;

    // Reset values.
    do_reset();
    check("reset read_ctrl", 64'(read_ctrl), 64'd0);
    check("reset m_valid", 64'(m_valid), 64'd0);
    check("reset m_last", 64'(m_last), 64'd0);
    check("reset m_data", 64'(m_data), 64'd0);
    check("reset rec_count", 64'(rec_count), 64'd0);

    // Single record, word k = k+1.
    for (int k = 0; k < 6; k++) r0[32*k +: 32] = 32'(k + 1);
    push_rec(r0);
    drain("single", 0, 400);
    check("single pulses", 64'(pulses), 64'd1);
    check("single pulse phase", 64'(bad_phase), 64'd0);
    if (got_q.size() == 6) check("single last word", 64'(got_q[5]), {31'd0, 1'b1, 32'd6});
    cmp_stream("single");

    // Backpressure: host stalls, only BufDepth requests may be issued.
    do_reset();
    r0 = rand_rec();
    r0[31:0] = $urandom | 32'h1;
    push_rec(r0);
    for (int i = 0; i < 4; i++) push_rec(rand_rec());
    repeat (100) @(negedge clk);
    check("stall pulses", 64'(pulses), 64'(BufDepth));
    check("stall m_valid", 64'(m_valid), 64'd1);
    check("stall m_data", 64'(m_data), 64'(r0[31:0]));
    check("stall m_last", 64'(m_last), 64'd0);
    drain("stall", 0, 2000);
    check("stall total pulses", 64'(pulses), 64'd5);
    check("stall stable", 64'(unstable), 64'd0);
    check("stall pulse phase", 64'(bad_phase), 64'd0);
    cmp_stream("stall");

    // Three records with ready toggling every cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r0 = rand_rec();
      r0[0] = 1'b1;
      push_rec(r0);
    end
    drain("toggle", 1, 2000);
    check("toggle stable", 64'(unstable), 64'd0);
    cmp_stream("toggle");

    // All-zero record followed by a normal one.
    do_reset();
    push_rec('0);
    r0 = rand_rec();
    r0[5] = 1'b1;
    push_rec(r0);
    drain("zero", 0, 1000);
    cmp_stream("zero");

    // Random records and random host backpressure.
    do_reset();
    for (int i = 0; i < 30; i++) push_rec(rand_rec());
    drain("random", 2, 4000);
    check("random stable", 64'(unstable), 64'd0);
    check("random pulse phase", 64'(bad_phase), 64'd0);
    cmp_stream("random");

    // Reset in the middle of a record.
    do_reset();
    ra = rand_rec();
    ra[0] = 1'b1;
    push_rec(ra);
    push_rec(rand_rec());
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst valid seen", 64'(n < 200), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 m_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1 m_ready = 1'b0;
    #1 check("midrst word 3", 64'({m_last, m_data}), 64'({1'b0, ra[127:96]}));
    #1 reset = 1'b1;
    #1;
    check("midrst read_ctrl", 64'(read_ctrl), 64'd0);
    check("midrst m_valid", 64'(m_valid), 64'd0);
    check("midrst m_last", 64'(m_last), 64'd0);
    check("midrst m_data", 64'(m_data), 64'd0);
    check("midrst rec_count", 64'(rec_count), 64'd0);
    do_reset();
    m_ready = 1'b1;
    repeat (80) @(negedge clk);
    check("postrst valid cycles", 64'(valid_cycles), 64'd0);
    check("postrst rec_count", 64'(rec_count), 64'd0);
    check("postrst pulses", 64'(pulses), 64'd0);
    r0 = rand_rec();
    r0[9] = 1'b1;
    push_rec(r0);
    drain("postrst", 0, 400);
    cmp_stream("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
